sync_fifo_flagged: RTL and testbench

Parametrised successor to the project's simple synchronous FIFO. Single-clock circular-buffer FIFO that adds:
- a fill count
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags
- a synchronous flush
- a build-time choice between registered-read and first-word-fall-through (FWFT) output
It sits between producer and consumer stages inside one clock domain, for example in front of the RAM datapath.

---
 rtl/sync_fifo_pkg.sv | 19 +
 rtl/fifo_mem_2p.sv | 29 ++
 rtl/sync_fifo_flagged.sv | 148 ++++++++++++++
 tb/tb_sync_fifo_flagged.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the flagged synchronous FIFO family.
package sync_fifo_pkg;

  // Pointer width needed to address a FIFO of the given depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Status bundle for higher-level blocks that collect FIFO flags.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port register file: one synchronous write port, one asynchronous read port.
module fifo_mem_2p
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              wr_en,
  input  logic [ptr_w(FIFO_DEPTH)-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic [ptr_w(FIFO_DEPTH)-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0]             rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // Write port: store the word on an accepted push.
  // NOTE: the array has no reset; occupancy is tracked by the count register,
  // so stale contents are never observed and the array can map onto plain storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_flagged.sv
// Single-clock circular-buffer FIFO with fill count, threshold flags,
// sticky error flags, synchronous flush and selectable read mode.
module sync_fifo_flagged
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fill_count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Reject unusable configurations while elaborating.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_flagged: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > FIFO_DEPTH)) begin : g_bad_af
    $error("sync_fifo_flagged: AF_THRESH must be in 1..FIFO_DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > FIFO_DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_flagged: AE_THRESH must be in 0..FIFO_DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags come straight from the count register.
  assign fifo_full    = (count_q == DEPTH_C);
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign fill_count   = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO still takes a push when a pop frees a slot in the same cycle;
  // an empty FIFO has no bypass, so a simultaneous pop is rejected.
  assign pop_ok  = pop & ~fifo_empty;
  assign push_ok = push & (~fifo_full | pop_ok);

  // Next-state for pointers, count and sticky errors; flush wins over traffic.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      if (push && !push_ok) overflow_d  = 1'b1;
      if (pop  && !pop_ok)  underflow_d = 1'b1;
    end
  end

  // State registers with asynchronous clear.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok & ~flush),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rdata)
  );

  if (FWFT == 0) begin : g_reg_read
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Registered read: capture the head word on an accepted pop; data holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (flush) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= pop_ok;
        if (pop_ok) rd_data_q <= mem_rdata;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_fwft
    // Head word is presented directly; masked to zero while empty so reset reads as 0.
    assign rd_valid = ~fifo_empty;
    assign rd_data  = fifo_empty ? '0 : mem_rdata;
  end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed testbench for sync_fifo_flagged: one registered-read instance and one FWFT instance.
module tb_sync_fifo_flagged;

  logic        clk;
  logic        reset_n;

  logic        flush0, push0, pop0;
  logic [31:0] wr0, rd0;
  logic        rv0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [4:0]  cnt0;

  logic        flush1, push1, pop1;
  logic [31:0] wr1, rd1;
  logic        rv1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]  cnt1;

  int tests_run = 0;
  int tests_failed = 0;

  sync_fifo_flagged #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .FWFT(0)) u_reg (
    .clk(clk), .reset_n(reset_n), .flush(flush0), .push(push0), .wr_data(wr0),
    .pop(pop0), .rd_data(rd0), .rd_valid(rv0), .fifo_full(full0), .fifo_empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .fill_count(cnt0),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_flagged #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .FWFT(1)) u_fwft (
    .clk(clk), .reset_n(reset_n), .flush(flush1), .push(push1), .wr_data(wr1),
    .pop(pop1), .rd_data(rd1), .rd_valid(rv1), .fifo_full(full1), .fifo_empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .fill_count(cnt1),
    .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    flush0 = 0; push0 = 0; pop0 = 0; wr0 = '0;
    flush1 = 0; push1 = 0; pop1 = 0; wr1 = '0;
    #1;
    // Reset values.
    check("rst_empty",  32'(empty0), 32'd1);
    check("rst_aempty", 32'(ae0),    32'd1);
    check("rst_full",   32'(full0),  32'd0);
    check("rst_afull",  32'(af0),    32'd0);
    check("rst_count",  32'(cnt0),   32'd0);
    check("rst_ovf",    32'(ovf0),   32'd0);
    check("rst_unf",    32'(unf0),   32'd0);
    check("rst_rvalid", 32'(rv0),    32'd0);
    check("rst_rdata",  rd0,         32'd0);
    check("rst_fwft_rvalid", 32'(rv1), 32'd0);
    check("rst_fwft_rdata",  rd1,      32'd0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();

    // Single word.
    push0 = 1; wr0 = 32'hAA; cyc(); push0 = 0;
    check("single_count", 32'(cnt0),   32'd1);
    check("single_empty", 32'(empty0), 32'd0);
    pop0 = 1; cyc(); pop0 = 0;
    check("single_rvalid", 32'(rv0),    32'd1);
    check("single_rdata",  rd0,         32'hAA);
    check("single_empty2", 32'(empty0), 32'd1);
    cyc();
    check("single_rvalid_drop", 32'(rv0), 32'd0);
    check("single_rdata_hold",  rd0,      32'hAA);

    // Fill 0..15 and watch thresholds.
    for (int i = 0; i < 16; i++) begin
      push0 = 1; wr0 = 32'(i); cyc();
      if (i + 1 == 2)  check("ae_at_2",  32'(ae0), 32'd1);
      if (i + 1 == 3)  check("ae_at_3",  32'(ae0), 32'd0);
      if (i + 1 == 13) check("af_at_13", 32'(af0), 32'd0);
      if (i + 1 == 14) check("af_at_14", 32'(af0), 32'd1);
      if (i + 1 == 15) check("full_at_15", 32'(full0), 32'd0);
    end
    push0 = 0;
    check("fill_full",  32'(full0), 32'd1);
    check("fill_count", 32'(cnt0),  32'd16);

    // Pop 8, push 16..23 so both pointers wrap.
    for (int i = 0; i < 8; i++) begin
      pop0 = 1; cyc();
      check("pop8_rdata", rd0, 32'(i));
    end
    pop0 = 0;
    check("pop8_count", 32'(cnt0), 32'd8);
    for (int i = 16; i < 24; i++) begin
      push0 = 1; wr0 = 32'(i); cyc();
    end
    push0 = 0;
    check("wrap_full", 32'(full0), 32'd1);

    // Drain: 8..23 in order, valid every cycle.
    for (int i = 8; i < 24; i++) begin
      pop0 = 1; cyc();
      check("drain_rdata",  rd0,      32'(i));
      check("drain_rvalid", 32'(rv0), 32'd1);
    end
    pop0 = 0;
    check("drain_empty", 32'(empty0), 32'd1);

    // Push and pop together while empty: only the push is taken.
    push0 = 1; pop0 = 1; wr0 = 32'h66; cyc(); push0 = 0; pop0 = 0;
    check("emptypp_count",  32'(cnt0), 32'd1);
    check("emptypp_unf",    32'(unf0), 32'd1);
    check("emptypp_rvalid", 32'(rv0),  32'd0);

    // Refill to full, then push and pop together.
    for (int i = 0; i < 15; i++) begin
      push0 = 1; wr0 = 32'h100 + 32'(i); cyc();
    end
    push0 = 0;
    check("refill_full", 32'(full0), 32'd1);
    push0 = 1; pop0 = 1; wr0 = 32'h55; cyc(); push0 = 0; pop0 = 0;
    check("fullpp_count", 32'(cnt0),  32'd16);
    check("fullpp_full",  32'(full0), 32'd1);
    check("fullpp_ovf",   32'(ovf0),  32'd0);
    check("fullpp_rdata", rd0,        32'h66);

    // Overflow stickiness.
    push0 = 1; wr0 = 32'h77; cyc(); push0 = 0;
    check("ovf_set",   32'(ovf0), 32'd1);
    check("ovf_count", 32'(cnt0), 32'd16);
    pop0 = 1; cyc(); pop0 = 0;
    check("ovf_pop_rdata", rd0,        32'h100);
    check("ovf_sticky",    32'(ovf0),  32'd1);
    check("ovf_count2",    32'(cnt0),  32'd15);

    // Flush beats a simultaneous push.
    flush0 = 1; push0 = 1; wr0 = 32'h99; cyc(); flush0 = 0; push0 = 0;
    check("flush_ovf",    32'(ovf0),   32'd0);
    check("flush_unf",    32'(unf0),   32'd0);
    check("flush_count",  32'(cnt0),   32'd0);
    check("flush_empty",  32'(empty0), 32'd1);
    check("flush_rvalid", 32'(rv0),    32'd0);

    // Underflow, then five words, then asynchronous reset between edges.
    pop0 = 1; cyc(); pop0 = 0;
    check("unf_set", 32'(unf0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      push0 = 1; wr0 = 32'hA0 + 32'(i); cyc();
    end
    push0 = 0;
    check("pre_rst_count", 32'(cnt0), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    check("arst_count",  32'(cnt0),   32'd0);
    check("arst_empty",  32'(empty0), 32'd1);
    check("arst_aempty", 32'(ae0),    32'd1);
    check("arst_unf",    32'(unf0),   32'd0);
    check("arst_rdata",  rd0,         32'd0);
    #2 reset_n = 1'b1;
    cyc();
    push0 = 1; wr0 = 32'h11; cyc(); push0 = 0;
    pop0 = 1; cyc(); pop0 = 0;
    check("post_rst_rdata",  rd0,      32'h11);
    check("post_rst_rvalid", 32'(rv0), 32'd1);

    // FWFT instance.
    push1 = 1; wr1 = 32'hBB; cyc();
    check("fwft_first_rvalid", 32'(rv1), 32'd1);
    check("fwft_first_rdata",  rd1,      32'hBB);
    wr1 = 32'hCC; cyc(); push1 = 0;
    check("fwft_hold_rdata", rd1,        32'hBB);
    check("fwft_count",      32'(cnt1),  32'd2);
    pop1 = 1; cyc(); pop1 = 0;
    check("fwft_next_rdata",  rd1,      32'hCC);
    check("fwft_next_rvalid", 32'(rv1), 32'd1);
    pop1 = 1; cyc(); pop1 = 0;
    check("fwft_drained_rvalid", 32'(rv1),    32'd0);
    check("fwft_drained_empty",  32'(empty1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
